fifo_rd_stream: RTL and testbench

//  Read-side drain stage for generic_fifo_sc_a / generic_fifo_dc (read port).

---
 rtl/fifo_rd_stream.sv | 104 ++++++++++
 tb/tb_fifo_rd_stream.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: issues fifo_re, absorbs the 1-clk read latency in a 2-entry skid buffer,
// and presents a valid/ready stream with out_last every PKT_LEN beats. Optional stats: FRS_STATS_EN.
module fifo_rd_stream #(
   parameter int DW      = 8,
   parameter int PKT_LEN = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          fifo_empty,
   input  logic [DW-1:0] fifo_dout,
   output logic          fifo_re,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic [31:0]   stat_words,
   output logic [15:0]   stat_stall
);
   localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;

   occ_t          occ;
   logic          inflight;
   logic [DW-1:0] head, tail;
   logic [CW-1:0] cnt;
   logic          pop, arrive;
   logic [2:0]    need;

   assign pop       = out_valid & out_ready;
   assign arrive    = inflight;
   assign out_valid = (occ != EMPTY);
   assign out_data  = head;
   assign out_last  = out_valid && (cnt == LAST_BEAT);

   // Slots committed after this edge: held words plus the one already on its way.
   assign need    = 3'(occ) + 3'(inflight) - 3'(pop);
   assign fifo_re = !rst && !fifo_empty && !clr && (need < 3'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         occ      <= EMPTY;
         inflight <= 1'b0;
         head     <= '0;
         tail     <= '0;
         cnt      <= '0;
      end else begin
         inflight <= fifo_re;
         if (clr) begin
            // Any word arriving this cycle is dropped along with the buffer.
            occ <= EMPTY;
            cnt <= '0;
         end else begin
            if (pop) cnt <= (cnt == LAST_BEAT) ? '0 : cnt + CW'(1);
            case (occ)
               EMPTY: if (arrive) begin
                  head <= fifo_dout;
                  occ  <= ONE;
               end
               ONE: begin
                  if (arrive && pop) head <= fifo_dout;
                  else if (arrive) begin
                     tail <= fifo_dout;
                     occ  <= TWO;
                  end else if (pop) occ <= EMPTY;
               end
               TWO: if (pop) begin
                  head <= tail;
                  if (arrive) tail <= fifo_dout;
                  else occ <= ONE;
               end
               default: occ <= EMPTY;
            endcase
         end
      end
   end

   // The read credit must never let a word land on a full buffer.
   assert property (@(posedge clk) disable iff (rst) !(occ == TWO && arrive && !pop && !clr));

`ifdef FRS_STATS_EN
   logic [31:0] words_q;
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         words_q <= '0;
         stall_q <= '0;
      end else begin
         if (pop) words_q <= words_q + 32'd1;
         if (out_valid && !out_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      end
   end

   assign stat_words = words_q;
   assign stat_stall = stall_q;
`else
   assign stat_words = '0;
   assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO + queue-based reference of the skid stage,
// directed phases followed by a randomized phase.
module tb_fifo_rd_stream;
   localparam int DW      = 8;
   localparam int PKT_LEN = 4;

   logic          clk;
   logic          rst, clr, fifo_empty, out_ready;
   logic [DW-1:0] fifo_dout;
   logic          fifo_re, out_valid, out_last;
   logic [DW-1:0] out_data;
   logic [31:0]   stat_words;
   logic [15:0]   stat_stall;

   fifo_rd_stream #(.DW(DW), .PKT_LEN(PKT_LEN)) dut (
      .clk(clk), .rst(rst), .clr(clr), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .fifo_re(fifo_re), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .stat_words(stat_words), .stat_stall(stat_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // FIFO contents, reference buffer, word in flight, beat position, stats.
   logic [DW-1:0] fq[$];
   logic [DW-1:0] mbuf[$];
   logic          mfly = 1'b0;
   logic [DW-1:0] mfly_data = '0;
   int            beats = 0;
   logic [31:0]   mw = '0;
   logic [15:0]   ms = '0;

   logic [DW-1:0] got[$];
   int            gotcyc[$];
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: entered at a negedge with inputs set; checks, advances the model, returns at next negedge.
   task automatic step();
      logic exp_valid, exp_re, exp_last, pop, re_dut;
      int   occf;
      fifo_empty = (fq.size() == 0);
      #1;
      exp_valid = (mbuf.size() != 0);
      pop       = exp_valid && out_ready;
      occf      = mbuf.size() + int'(mfly) - int'(pop);
      exp_re    = !rst && !fifo_empty && !clr && (occf < 2);
      exp_last  = exp_valid && (beats == PKT_LEN - 1);

      chk("out_valid", out_valid, exp_valid);
      chk("fifo_re", fifo_re, exp_re);
      chk("out_last", out_last, exp_last);
      if (exp_valid) chk("out_data", out_data, mbuf[0]);
      if (prev_stall) begin
         chk("hold_data", out_data, prev_data);
         chk("hold_last", out_last, prev_last);
      end
      chk("stat_words", stat_words, `ifdef FRS_STATS_EN mw `else 32'd0 `endif);
      chk("stat_stall", stat_stall, `ifdef FRS_STATS_EN ms `else 32'd0 `endif);
      chk("occ_le_2", (mbuf.size() + int'(mfly)) <= 2, 1);

      if (out_valid && out_ready && !clr && !rst) begin
         got.push_back(out_data);
         gotcyc.push_back(cyc);
      end
      prev_stall = exp_valid && !out_ready && !clr && !rst;
      prev_data  = out_data;
      prev_last  = out_last;

      if (rst) begin
         mbuf.delete();
         mfly = 1'b0;
         beats = 0;
         mw = '0;
         ms = '0;
      end else begin
         if (pop) mw = mw + 32'd1;
         if (exp_valid && !out_ready && ms != 16'hFFFF) ms = ms + 16'd1;
         if (clr) begin
            mbuf.delete();
            mfly = 1'b0;
            beats = 0;
         end else begin
            if (pop) begin
               void'(mbuf.pop_front());
               beats = (beats + 1) % PKT_LEN;
            end
            if (mfly) mbuf.push_back(mfly_data);
            mfly = exp_re;
            if (exp_re) mfly_data = fq[0];
         end
      end

      re_dut = fifo_re;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      // Registered read port: the popped word is presented for the next capture edge.
      if (re_dut && fq.size() > 0) fifo_dout = fq.pop_front();
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
      @(posedge clk);
      @(negedge clk);

      // Reset
      step(); step();
      chk("rst_data", out_data, 0);
      chk("rst_valid", out_valid, 0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) step();

      // Streaming 0x01..0x10 with ready held high
      got.delete(); gotcyc.delete();
      for (int i = 1; i <= 16; i++) fq.push_back(8'(i));
      out_ready = 1'b1;
      for (int i = 0; i < 22; i++) step();
      chk("t2_count", got.size(), 16);
      if (got.size() == 16) begin
         chk("t2_first", got[0], 8'h01);
         chk("t2_lastword", got[15], 8'h10);
         chk("t2_span", gotcyc[15] - gotcyc[0], 15);
      end

      // Backpressure 1,0,0,1
      for (int i = 0; i < 8; i++) fq.push_back(8'h20 + 8'(i));
      for (int i = 0; i < 40; i++) begin
         out_ready = (i % 4 == 0) || (i % 4 == 3);
         step();
      end

      // clr with a word in flight
      got.delete(); gotcyc.delete();
      for (int i = 0; i < 6; i++) fq.push_back(8'h40 + 8'(i));
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) step();
      out_ready = 1'b1;
      step();
      clr = 1'b1;
      step();
      clr = 1'b0; out_ready = 1'b0;
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();
      if (got.size() > 1) chk("t4_after_clr", got[1], 8'h43);
      else chk("t4_after_clr_count", got.size(), 2);

      // Single word across the empty boundary
      got.delete();
      fq.push_back(8'hA5);
      for (int i = 0; i < 6; i++) step();
      chk("t5_count", got.size(), 1);
      if (got.size() == 1) chk("t5_word", got[0], 8'hA5);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(2) == 0 && fq.size() < 20) fq.push_back(8'($urandom));
         out_ready = ($urandom_range(2) != 0);
         clr = ($urandom_range(39) == 0);
         step();
      end
      clr = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 30; i++) step();

      // Stats: 10 beats, 7 stall cycles after a fresh reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) fq.push_back(8'h80 + 8'(i));
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) step();
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) step();
`ifdef FRS_STATS_EN
      chk("t6_words", stat_words, 32'd10);
      chk("t6_stall", stat_stall, 32'd7);
`else
      chk("t6_words_off", stat_words, 32'd0);
      chk("t6_stall_off", stat_stall, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
